// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, default width.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MADDU = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;
  localparam logic [2:0] OP_MSUBU = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Radix-2 restoring divide core on unsigned magnitudes.
// load captures operands and clears the counter; each step retires one quotient bit;
// finish is high while the step that produces the last quotient bit is being applied.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             finish
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;

  // Trial subtraction of the divisor from the partial remainder shifted left by one.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    fits    = ~diff[WIDTH];
  end

  // Quotient shifts in from the bottom while dividend bits leave from the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      rem_q <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_q <= {quo_q[WIDTH-2:0], fits};
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign finish    = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit feeding the HI/LO register pair.
// Optional feature macro: MULDIV_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 4-7);
// without it those ops are rejected at issue and hi_in/lo_in are unused.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] whidata,
  output logic [WIDTH-1:0] wlodata,
  output logic             whien,
  output logic             wloen
);

  state_t             state, next_state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               op_legal, accept, b_zero;
  logic               div_load, div_step, div_finish, div_signed_in;
  logic [WIDTH-1:0]   dvd_mag, dvs_mag, div_quo, div_rem;
  logic               neg_q, neg_r;
  logic [WIDTH-1:0]   fix_hi, fix_lo, res_hi, res_lo;
  logic               mul_signed;
  logic [2*WIDTH-1:0] mul_x, mul_y, mul_prod, mul_res;
  logic               done_q;

`ifdef MULDIV_MADD_EN
  logic [WIDTH-1:0]   hi_q, lo_q;
  assign op_legal = 1'b1;
`else
  logic               unused_acc;
  assign op_legal   = ~op[2];
  assign unused_acc = ^{hi_in, lo_in};
`endif

  assign accept   = start && !flush && op_legal && (state == S_IDLE);
  assign b_zero   = (b_q == '0);
  assign div_load = accept && is_div_op(op);
  assign div_step = (state == S_DIV) && !b_zero;

  // Operand capture at issue; later input changes do not affect the operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
`ifdef MULDIV_MADD_EN
      hi_q <= '0;
      lo_q <= '0;
`endif
    end else if (accept) begin
      op_q <= op;
      a_q  <= opa;
      b_q  <= opb;
`ifdef MULDIV_MADD_EN
      hi_q <= hi_in;
      lo_q <= lo_in;
`endif
    end
  end

  // Magnitudes handed to the divide core straight from the issuing operands.
  always_comb begin
    div_signed_in = (op == OP_DIV);
    dvd_mag = (div_signed_in && opa[WIDTH-1]) ? -opa : opa;
    dvs_mag = (div_signed_in && opb[WIDTH-1]) ? -opb : opb;
  end

  div_iter #(
    .WIDTH (WIDTH)
  ) u_div_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .step      (div_step),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .quotient  (div_quo),
    .remainder (div_rem),
    .finish    (div_finish)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; flush aborts everything except an already-committed DONE.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: if (accept) next_state = is_div_op(op) ? S_DIV : S_MUL;
      S_MUL:  next_state = S_DONE;
      S_DIV:  if (b_zero || div_finish) next_state = S_FIX;
      S_FIX:  next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (flush && (state != S_DONE)) next_state = S_IDLE;
  end

  // Full-width product from sign- or zero-extended operands, optionally accumulated.
  always_comb begin
    mul_signed = ~op_q[0];
    mul_x = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    mul_y = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    mul_prod = mul_x * mul_y;
    mul_res  = mul_prod;
`ifdef MULDIV_MADD_EN
    if (op_q[2]) mul_res = op_q[1] ? ({hi_q, lo_q} - mul_prod) : ({hi_q, lo_q} + mul_prod);
`endif
  end

  // Sign fix: quotient truncates toward zero, remainder follows the dividend.
  always_comb begin
    neg_q = (op_q == OP_DIV) && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    neg_r = (op_q == OP_DIV) && a_q[WIDTH-1];
    if (b_zero) begin
      fix_lo = '1;
      fix_hi = a_q;
    end else begin
      fix_lo = neg_q ? -div_quo : div_quo;
      fix_hi = neg_r ? -div_rem : div_rem;
    end
    res_hi = (state == S_MUL) ? mul_res[2*WIDTH-1:WIDTH] : fix_hi;
    res_lo = (state == S_MUL) ? mul_res[WIDTH-1:0]       : fix_lo;
  end

  // Registered write port: data and a one-cycle strobe on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q  <= 1'b0;
      whidata <= '0;
      wlodata <= '0;
    end else begin
      done_q <= (next_state == S_DONE);
      if (next_state == S_DONE) begin
        whidata <= res_hi;
        wlodata <= res_lo;
      end
    end
  end

  assign busy  = (state != S_IDLE);
  assign done  = done_q;
  assign whien = done_q;
  assign wloen = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model plus a per-cycle
// compare of busy/done/write enables and, on each expected write, HI/LO data.
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic [2:0]    op = '0;
  logic [W-1:0]  opa = '0, opb = '0, hi_in = '0, lo_in = '0;
  logic          busy, done, whien, wloen;
  logic [W-1:0]  whidata, wlodata;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .hi_in(hi_in), .lo_in(lo_in), .flush(flush), .busy(busy), .done(done),
    .whidata(whidata), .wlodata(wlodata), .whien(whien), .wloen(wloen)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: what HI/LO must hold after an op.
  function automatic logic [63:0] model_res(input logic [2:0] o, input logic [31:0] a, b, h, l);
    longint sa, sb;
    int     ia, ib;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ia = a;
    ib = b;
    case (o)
      3'd0: return sa * sb;
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {ia % ib, ia / ib};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        p = o[0] ? {32'd0, a} * {32'd0, b} : sa * sb;
        return o[1] ? {h, l} - p : {h, l} + p;
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] b);
    if (o == 3'd2 || o == 3'd3) return (b == 0) ? 3 : W + 2;
    return 2;
  endfunction

  function automatic bit model_legal(input logic [2:0] o);
`ifdef MULDIV_MADD_EN
    return 1'b1;
`else
    return o < 3'd4;
`endif
  endfunction

  // Expected-timeline scoreboard (cyc counts rising edges; start sampled at edge iss).
  bit          run = 1'b0;
  bit          pend = 1'b0;
  int          iss = 0, busy_end = -1, done_at = -1;
  logic [63:0] exp_res = '0;
  int          dones = 0, exp_dones = 0;
  logic        eb, ed;

  always @(negedge clk) begin
    if (run) begin
      eb = pend && (cyc >= iss) && (cyc <= busy_end);
      ed = pend && (cyc == done_at);
      chk("busy", {63'd0, busy}, {63'd0, eb});
      chk("done", {63'd0, done}, {63'd0, ed});
      chk("whien", {63'd0, whien}, {63'd0, ed});
      chk("wloen", {63'd0, wloen}, {63'd0, ed});
      if (done) dones++;
      if (ed) begin
        chk("hi", {32'd0, whidata}, {32'd0, exp_res[63:32]});
        chk("lo", {32'd0, wlodata}, {32'd0, exp_res[31:0]});
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, b, h, l,
                       input bit pin, input logic [63:0] lit, input string nm);
    @(negedge clk);
    #1;
    flush = 1'b0;
    start = 1'b1;
    op = o; opa = a; opb = b; hi_in = h; lo_in = l;
    if (model_legal(o)) begin
      pend     = 1'b1;
      iss      = cyc + 1;
      done_at  = iss + model_lat(o, b) - 1;
      busy_end = done_at;
      exp_res  = model_res(o, a, b, h, l);
      exp_dones++;
      if (pin) chk(nm, exp_res, lit);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    opa = $urandom; opb = $urandom; hi_in = $urandom; lo_in = $urandom;
  endtask

  // Returns at the DONE-cycle negedge so the next issue is back-to-back.
  task automatic wait_idle();
    while (pend && cyc < busy_end) @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a, b;
    bit          pin;
    logic [63:0] lit;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA};
    vt[1] = '{3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 64'h0000_0002_FFFF_FFFA};
    vt[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD};
    vt[3] = '{3'd3, 32'd100, 32'd7, 1'b1, 64'h0000_0002_0000_000E};
    vt[4] = '{3'd2, 32'h1234_5678, 32'd0, 1'b1, 64'h1234_5678_FFFF_FFFF};
    vt[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000};
    vt[6] = '{3'd2, 32'd7, 32'hFFFF_FFFE, 1'b1, 64'h0000_0001_FFFF_FFFD};
    vt[7] = '{3'd3, 32'hFFFF_FFFF, 32'd3, 1'b0, 64'd0};
    vt[8] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    vt[9] = '{3'd3, 32'd5, 32'd0, 1'b0, 64'd0};

    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_whien", {63'd0, whien}, 64'd0);
    chk("rst_wloen", {63'd0, wloen}, 64'd0);
    chk("rst_hi", {32'd0, whidata}, 64'd0);
    chk("rst_lo", {32'd0, wlodata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b1;

    foreach (vt[i]) begin
      wait_idle();
      issue(vt[i].o, vt[i].a, vt[i].b, 32'd0, 32'd0, vt[i].pin, vt[i].lit,
            $sformatf("model_v%0d", i));
    end

    // Start while busy is ignored.
    wait_idle();
    issue(3'd3, 32'd1000, 32'd33, 0, 0, 1'b0, 64'd0, "");
    repeat (4) @(negedge clk);
    #1;
    start = 1'b1; op = 3'd0; opa = 32'd9; opb = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;

    // Flush at k+10 aborts the divide; MULT re-issued at k+11.
    wait_idle();
    issue(3'd2, 32'hFFFF_0000, 32'd17, 0, 0, 1'b0, 64'd0, "");
    while (cyc < iss + 9) @(negedge clk);
    #1;
    flush = 1'b1;
    busy_end = cyc;
    done_at = -1;
    exp_dones--;
    issue(3'd0, 32'd6, 32'd7, 0, 0, 1'b1, 64'd42, "model_reissue");

    // Flush in the DONE cycle does not cancel the write already made.
    wait_idle();
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;

    // start together with flush: flush wins.
    @(negedge clk);
    #1;
    start = 1'b1; flush = 1'b1; op = 3'd1; opa = 32'd3; opb = 32'd4;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);

    // Accumulate ops: legal only with the feature enabled.
`ifdef MULDIV_MADD_EN
    issue(3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b1, 64'h0000_0001_0000_0000, "model_maddu");
    wait_idle();
    issue(3'd6, 32'd2, 32'd3, 32'd0, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "model_msub");
    wait_idle();
`else
    issue(3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 64'd0, "");
    repeat (4) @(negedge clk);
`endif

    // Asynchronous reset mid-divide: immediate idle, outputs cleared, no write.
    wait_idle();
    issue(3'd3, 32'd77, 32'd5, 0, 0, 1'b0, 64'd0, "");
    repeat (5) @(negedge clk);
    #1;
    rst_n = 1'b0;
    pend = 1'b0;
    exp_dones--;
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_done", {63'd0, done}, 64'd0);
    chk("mid_rst_hi", {32'd0, whidata}, 64'd0);
    chk("mid_rst_lo", {32'd0, wlodata}, 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // One final op after reset to confirm the unit recovers.
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b1, 64'hFFFF_FFFE_0000_0001, "model_multu_max");
    wait_idle();
    repeat (3) @(negedge clk);
    chk("done_count", 64'(dones), 64'(exp_dones));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
